mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access.sv | 212 +++++++++++++++++++++
 tb/tb_mem_access.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM stage (master) and the memory/bridge (slave).
// Request side is registered by the master; the slave answers with a single-cycle ack.
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_sel, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM stage: runs big-endian loads/stores over a req/ack bus and stalls the pipeline meanwhile.
// Define MEM_ALIGN_CHK_EN to add excp_misalign and suppress misaligned half/word accesses.
module mem_access #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_wreg,
  input  logic [4:0]   mem_waddr,
  input  logic [31:0]  mem_wdata,
  input  logic         mem_whilo,
  input  logic [31:0]  mem_hi,
  input  logic [31:0]  mem_lo,
  input  logic [7:0]   mem_aluop,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_sdata,
  input  logic [5:0]   stall,
  output logic         wb_wreg,
  output logic [4:0]   wb_waddr,
  output logic [31:0]  wb_wdata,
  output logic         wb_whilo,
  output logic [31:0]  wb_hi,
  output logic [31:0]  wb_lo,
  mem_access_if.master bus,
  output logic         stallreq,
`ifdef MEM_ALIGN_CHK_EN
  output logic         excp_misalign,
`endif
  output logic         bus_err
);
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     data_q, data_d;
  logic            err_q, err_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      sel_q, sel_d;
  logic [31:0]     wdata_q, wdata_d;

  logic        is_load, is_store, is_byte, is_half, is_signed, is_mem, misalign;
  logic [3:0]  lane_sel;
  logic [31:0] st_wdata, ld_data;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_byte   = 1'b0;
    is_half   = 1'b0;
    is_signed = 1'b0;
    unique case (mem_aluop)
      OpLb:    begin is_load  = 1'b1; is_byte = 1'b1; is_signed = 1'b1; end
      OpLbu:   begin is_load  = 1'b1; is_byte = 1'b1; end
      OpLh:    begin is_load  = 1'b1; is_half = 1'b1; is_signed = 1'b1; end
      OpLhu:   begin is_load  = 1'b1; is_half = 1'b1; end
      OpLw:    is_load = 1'b1;
      OpSb:    begin is_store = 1'b1; is_byte = 1'b1; end
      OpSh:    begin is_store = 1'b1; is_half = 1'b1; end
      OpSw:    is_store = 1'b1;
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_CHK_EN
  assign misalign = is_mem && ((is_half && mem_addr[0]) ||
                               (!is_byte && !is_half && (mem_addr[1:0] != 2'b00)));
  assign excp_misalign = rst && (state_q == StIdle) && misalign;
`else
  assign misalign = 1'b0;
`endif

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    unique case (mem_addr[1:0])
      2'd0: ld_byte = bus.bus_rdata[31:24];
      2'd1: ld_byte = bus.bus_rdata[23:16];
      2'd2: ld_byte = bus.bus_rdata[15:8];
      2'd3: ld_byte = bus.bus_rdata[7:0];
    endcase
    ld_half = mem_addr[1] ? bus.bus_rdata[15:0] : bus.bus_rdata[31:16];
    if (is_byte) begin
      lane_sel = 4'b1000 >> mem_addr[1:0];
      st_wdata = {4{mem_sdata[7:0]}};
      ld_data  = is_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
    end else if (is_half) begin
      lane_sel = mem_addr[1] ? 4'b0011 : 4'b1100;
      st_wdata = {2{mem_sdata[15:0]}};
      ld_data  = is_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
    end else begin
      lane_sel = 4'b1111;
      st_wdata = mem_sdata;
      ld_data  = bus.bus_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle: begin
        if (is_mem && !misalign) begin
          state_d = StAccess;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = is_store;
          addr_d  = {mem_addr[31:2], 2'b00};
          sel_d   = lane_sel;
          wdata_d = is_store ? st_wdata : 32'h0;
        end
      end
      StAccess: begin
        cnt_d = cnt_q + CntW'(1);
        if (bus.bus_ack || (cnt_d == CntW'(TIMEOUT))) begin
          state_d = StDone;
          data_d  = (bus.bus_ack && is_load) ? ld_data : 32'h0;
          err_d   = !bus.bus_ack;
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = 32'h0;
          sel_d   = 4'h0;
          wdata_d = 32'h0;
        end
      end
      StDone: begin
        if (!stall[4]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= 32'h0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      sel_q   <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_wdata = wdata_q;
  assign bus_err       = err_q;

  // A stalled instruction must not commit a register write into MEM/WB.
  always_comb begin
    stallreq = 1'b0;
    wb_wreg  = 1'b0;
    wb_waddr = 5'h0;
    wb_wdata = 32'h0;
    wb_whilo = 1'b0;
    wb_hi    = 32'h0;
    wb_lo    = 32'h0;
    if (rst) begin
      case (state_q)
        StIdle:   stallreq = is_mem && !misalign;
        StAccess: stallreq = 1'b1;
        default:  stallreq = 1'b0;
      endcase
      wb_wreg  = mem_wreg && !stallreq && !misalign;
      wb_waddr = mem_waddr;
      wb_wdata = ((state_q == StDone) && is_load) ? data_q : mem_wdata;
      wb_whilo = mem_whilo && !stallreq;
      wb_hi    = mem_hi;
      wb_lo    = mem_lo;
    end
  end
endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: scoreboarded loads/stores against a latency-programmable bus slave,
// plus timeout, DONE hold, asynchronous reset mid-access and (if enabled) misalignment.
module tb_mem_access;
  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;
  localparam logic [7:0] OpAdd = 8'b0010_0000;
  localparam logic [7:0] OpNop = 8'b0000_0000;
  localparam logic [31:0] WbKeep = 32'h0BAD_0042;

  typedef struct packed {
    logic [31:0] wdata;
    logic        err;
  } exp_t;

  logic        clk, rst;
  logic        mem_wreg, mem_whilo;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_addr, mem_sdata;
  logic [7:0]  mem_aluop;
  logic [5:0]  stall;
  logic        wb_wreg, wb_whilo;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, wb_hi, wb_lo;
  logic        stallreq, bus_err;
`ifdef MEM_ALIGN_CHK_EN
  logic        excp_misalign;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  exp_t        sb_q[$];
  int          ack_lat;
  logic [31:0] slv_rdata;
  int          req_cycles;

  mem_access_if bus_if ();

  mem_access #(.TIMEOUT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_wreg      (mem_wreg),
    .mem_waddr     (mem_waddr),
    .mem_wdata     (mem_wdata),
    .mem_whilo     (mem_whilo),
    .mem_hi        (mem_hi),
    .mem_lo        (mem_lo),
    .mem_aluop     (mem_aluop),
    .mem_addr      (mem_addr),
    .mem_sdata     (mem_sdata),
    .stall         (stall),
    .wb_wreg       (wb_wreg),
    .wb_waddr      (wb_waddr),
    .wb_wdata      (wb_wdata),
    .wb_whilo      (wb_whilo),
    .wb_hi         (wb_hi),
    .wb_lo         (wb_lo),
    .bus           (bus_if),
    .stallreq      (stallreq),
`ifdef MEM_ALIGN_CHK_EN
    .excp_misalign (excp_misalign),
`endif
    .bus_err       (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  // Slave: ack after ack_lat cycles of bus_req (0 = never); rdata is garbage unless acking.
  always @(posedge clk or negedge rst) begin
    if (!rst) req_cycles <= 0;
    else if (bus_if.bus_req) req_cycles <= req_cycles + 1;
    else req_cycles <= 0;
  end

  always @(negedge clk) begin
    bus_if.bus_ack   = bus_if.bus_req && (ack_lat > 0) && (req_cycles == ack_lat - 1);
    bus_if.bus_rdata = bus_if.bus_ack ? slv_rdata : 32'hDEAD_BEEF;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic alu_op(input string tag, input logic [31:0] res);
    exp_t e;
    @(negedge clk);
    mem_aluop = OpAdd;
    mem_wdata = res;
    mem_wreg  = 1'b1;
    mem_hi    = ~res;
    e.wdata = res;
    e.err   = 1'b0;
    sb_q.push_back(e);
    #1;
    e = sb_q.pop_front();
    check_val({tag, "_wb"}, wb_wdata, e.wdata);
    check_val({tag, "_wreg"}, wb_wreg, 1);
    check_val({tag, "_hi"}, wb_hi, ~res);
    check_val({tag, "_stall"}, stallreq, 0);
    check_val({tag, "_req"}, bus_if.bus_req, 0);
  endtask

  task automatic mem_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                        input logic [31:0] sdata, input int lat, input logic [31:0] rdata,
                        input logic [3:0] e_sel, input logic [31:0] e_bwdata,
                        input logic [31:0] e_wb, input int e_stall, input int hold);
    exp_t e;
    int   n;
    logic seen, e_we;
    e_we = (op == OpSb) || (op == OpSh) || (op == OpSw);
    @(negedge clk);
    mem_aluop = op;
    mem_addr  = addr;
    mem_sdata = sdata;
    mem_wdata = WbKeep;
    mem_wreg  = 1'b1;
    ack_lat   = lat;
    slv_rdata = rdata;
    e.wdata = e_wb;
    e.err   = (lat == 0);
    sb_q.push_back(e);
    #1;
    n    = 0;
    seen = 1'b0;
    while (stallreq && n < 64) begin
      n++;
      if (bus_if.bus_req && !seen) begin
        seen = 1'b1;
        check_val({tag, "_addr"}, bus_if.bus_addr, addr & 32'hFFFF_FFFC);
        check_val({tag, "_sel"}, bus_if.bus_sel, e_sel);
        check_val({tag, "_we"}, bus_if.bus_we, e_we);
        check_val({tag, "_bwdata"}, bus_if.bus_wdata, e_bwdata);
      end
      @(negedge clk);
      #1;
    end
    check_val({tag, "_seen_req"}, seen, 1);
    check_val({tag, "_stall_cycles"}, n, e_stall);
    check_val({tag, "_req_done"}, bus_if.bus_req, 0);
    e = sb_q.pop_front();
    check_val({tag, "_wb"}, wb_wdata, e.wdata);
    check_val({tag, "_err"}, bus_err, e.err);
    if (hold > 0) begin
      stall = 6'b01_0000;
      repeat (hold) begin
        @(negedge clk);
        #1;
        check_val({tag, "_hold_wb"}, wb_wdata, e.wdata);
        check_val({tag, "_hold_stall"}, stallreq, 0);
      end
      stall = 6'b00_0000;
    end
    mem_aluop = OpNop;
    @(negedge clk);
    #1;
    check_val({tag, "_idle_err"}, bus_err, 0);
    check_val({tag, "_idle_stall"}, stallreq, 0);
  endtask

  initial begin
    rst       = 1'b0;
    mem_wreg  = 1'b1;
    mem_waddr = 5'd3;
    mem_wdata = 32'h0000_0055;
    mem_whilo = 1'b1;
    mem_hi    = 32'h0000_0077;
    mem_lo    = 32'h0000_0088;
    mem_aluop = OpAdd;
    mem_addr  = 32'h0;
    mem_sdata = 32'h0;
    stall     = 6'b0;
    ack_lat   = 0;
    slv_rdata = 32'h0;
    #3;
    check_val("rst_wb_wdata", wb_wdata, 0);
    check_val("rst_wb_wreg", wb_wreg, 0);
    check_val("rst_wb_whilo", wb_whilo, 0);
    check_val("rst_wb_hi", wb_hi, 0);
    check_val("rst_stallreq", stallreq, 0);
    check_val("rst_bus_req", bus_if.bus_req, 0);
    check_val("rst_bus_sel", bus_if.bus_sel, 0);
    check_val("rst_bus_err", bus_err, 0);
    @(negedge clk);
    rst = 1'b1;

    alu_op("add0", 32'h0000_0005);
    //     tag      op     addr          sdata         lat rdata         sel      bwdata
    mem_op("lw",    OpLw,  32'h100, 32'h0,        2, 32'h1234_5678, 4'b1111, 32'h0,
           32'h1234_5678, 3, 2);
    mem_op("lb",    OpLb,  32'h103, 32'h0,        1, 32'h0000_00F0, 4'b0001, 32'h0,
           32'hFFFF_FFF0, 2, 0);
    mem_op("lbu",   OpLbu, 32'h103, 32'h0,        1, 32'h0000_00F0, 4'b0001, 32'h0,
           32'h0000_00F0, 2, 0);
    mem_op("lb0",   OpLb,  32'h100, 32'h0,        1, 32'h7F00_0000, 4'b1000, 32'h0,
           32'h0000_007F, 2, 0);
    mem_op("lh",    OpLh,  32'h102, 32'h0,        3, 32'h1234_8001, 4'b0011, 32'h0,
           32'hFFFF_8001, 4, 0);
    mem_op("lhu",   OpLhu, 32'h100, 32'h0,        1, 32'h8001_1234, 4'b1100, 32'h0,
           32'h0000_8001, 2, 0);
    mem_op("sh",    OpSh,  32'h202, 32'hAAAA_BEEF, 1, 32'h0,        4'b0011, 32'hBEEF_BEEF,
           WbKeep, 2, 0);
    mem_op("sb",    OpSb,  32'h201, 32'h1234_5699, 2, 32'h0,        4'b0100, 32'h9999_9999,
           WbKeep, 3, 0);
    mem_op("sw",    OpSw,  32'h204, 32'hCAFE_F00D, 1, 32'h0,        4'b1111, 32'hCAFE_F00D,
           WbKeep, 2, 1);
    mem_op("lw_to", OpLw,  32'h108, 32'h0,        0, 32'h5555_5555, 4'b1111, 32'h0,
           32'h0, 17, 0);
`ifndef MEM_ALIGN_CHK_EN
    mem_op("lw_odd", OpLw, 32'h10B, 32'h0,        1, 32'h0102_0304, 4'b1111, 32'h0,
           32'h0102_0304, 2, 0);
    mem_op("lh_odd", OpLhu, 32'h103, 32'h0,       1, 32'hAAAA_5566, 4'b0011, 32'h0,
           32'h0000_5566, 2, 0);
`endif
    alu_op("add1", 32'h0000_1234);

    // Asynchronous reset while the slave never acknowledges.
    @(negedge clk);
    mem_aluop = OpLw;
    mem_addr  = 32'h300;
    mem_wdata = 32'h0000_0077;
    ack_lat   = 0;
    @(negedge clk);
    #1;
    check_val("rstmid_req_pre", bus_if.bus_req, 1);
    #1 rst = 1'b0;
    #1;
    check_val("rstmid_req", bus_if.bus_req, 0);
    check_val("rstmid_stall", stallreq, 0);
    check_val("rstmid_wb", wb_wdata, 0);
    check_val("rstmid_sel", bus_if.bus_sel, 0);
    check_val("rstmid_addr", bus_if.bus_addr, 0);
    mem_aluop = OpAdd;
    @(negedge clk);
    rst = 1'b1;
    alu_op("rstmid_add", 32'h0000_0005);

`ifdef MEM_ALIGN_CHK_EN
    @(negedge clk);
    mem_aluop = OpLw;
    mem_addr  = 32'h101;
    mem_wreg  = 1'b1;
    #1;
    check_val("mis_excp", excp_misalign, 1);
    check_val("mis_req", bus_if.bus_req, 0);
    check_val("mis_wreg", wb_wreg, 0);
    check_val("mis_stall", stallreq, 0);
    @(negedge clk);
    #1;
    check_val("mis_noreq", bus_if.bus_req, 0);
    mem_aluop = OpNop;
`endif

    check_val("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
